digit_scan_controller: RTL
==========================

# digit_scan_controller

Time-multiplexed scan controller for the clock's four-digit display. It steps the 1:4 digit-select demux through digits 0→3 and inserts a blanking gap before each digit. During each digit's show window it presents that digit's BCD code to the segment decoder. New time values are double-buffered so a displayed frame never mixes old and new digits.

## Interface
Parameters:
- SHOW_CYC, 4: clock cycles each digit is lit (≥1).
- BLANK_CYC, 1: clock cycles of blanking before each digit (≥1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable, level-sensitive.
- load  input  1  single-cycle strobe that captures digits_in.
- digits_in  input  16  four BCD digits: [15:12] digit0 (hours tens), [11:8] digit1, [7:4] digit2, [3:0] digit3.
- lz_en  input  1  leading-zero suppression for digit0.
- sel  output  [0:1]  demux select. sel[0] is the upper bit, so digit index d = {sel[0],sel[1]}.
- seg_on  output  1  active-high segment enable, to be ANDed into the segment drive.
- bcd_out  output  4  BCD code of the current digit.
- frame_start  output  1  one-cycle pulse at the start of each frame.
- bcd_err  output  1  sticky flag; set when a non-BCD digit is shown.

## Operation
- Registers:
  - pending[15:0] with a pend flag.
  - shadow[15:0], which holds the displayed frame.
  - idx[1:0]: current digit index.
  - cnt: phase counter, wide enough for max(SHOW_CYC, BLANK_CYC).
  - state ∈ {IDLE, BLANK, SHOW}.
- Reset values:
  - state=IDLE, idx=0, cnt=0.
  - shadow=pending=0, pend=0.
  - Outputs: sel=00, seg_on=0, bcd_out=0, frame_start=0, bcd_err=0.
- IDLE:
  - sel=00, seg_on=0.
  - Goes to BLANK when enable=1. That transition is a frame boundary with idx=0.
- BLANK:
  - Lasts exactly BLANK_CYC cycles. seg_on=0, sel=idx.
  - Then goes to SHOW.
- SHOW:
  - Lasts exactly SHOW_CYC cycles. sel=idx, bcd_out=shadow digit idx.
  - seg_on=1, except in two cases where it stays 0:
    - the digit is >9;
    - idx=0, lz_en=1 and the digit equals 0.
  - At the end of SHOW, idx increments, wrapping 3→0, and the state goes to BLANK.
  - The 3→0 wrap is a frame boundary.
- Frame boundary (the cycle state enters BLANK with idx=0):
  - If pend=1: shadow←pending and pend←0.
  - frame_start=1 for that cycle.
- Load:
  - load=1 gives pending←digits_in and pend←1.
  - If load coincides with a frame boundary, digits_in goes straight to shadow and pend←0.
  - A second load before the boundary overwrites pending; last value wins.
- enable=0 in any state:
  - The next state is IDLE; seg_on=0 and sel=00 from that cycle on.
  - idx and cnt reset to 0. shadow and pending are retained.
  - Re-enabling always starts a fresh frame at digit 0.
- bcd_err is set in any SHOW cycle whose digit is >9. Only rst_n clears it.

## Timing
- All outputs are registered. Output changes appear one cycle after the state transition that causes them.
- Slot length is BLANK_CYC+SHOW_CYC. Frame length is 4×(BLANK_CYC+SHOW_CYC); with defaults that is 20 cycles.
- sel changes only when entering BLANK. It is never changed while seg_on=1, which gives ghost-free switching.
- From enable rising, frame_start asserts on the next cycle's outputs. The first seg_on=1 follows BLANK_CYC cycles later.
- Load-to-display latency is at most one frame plus one slot. It is 0 extra cycles when load hits the frame boundary.
- Reset is asynchronous: outputs take their reset values immediately, including mid-SHOW. Leaving reset requires enable=1 on a clock edge before scanning resumes.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-SHOW.
  - Required: seg_on drops to 0 and sel=00 without a clock edge; bcd_err=0.
- Basic scan (defaults):
  - Stimulus: load 16'h1234, enable=1.
  - Required: per 20-cycle frame, sel sequence 00,01,10,11; bcd_out 1,2,3,4; each digit lit for 4 cycles after a 1-cycle blank; frame_start every 20 cycles.
- Double-buffer:
  - Stimulus: load 16'h5678 during digit2's SHOW.
  - Required: the rest of the frame still shows 3,4. The next frame shows 5,6,7,8.
  - Also drive load coincident with a frame boundary: the new value is shown in that same frame.
- Leading zero:
  - Stimulus: digits 16'h0930 with lz_en=1.
  - Required: digit0 seg_on=0 throughout its SHOW. Digit3 (value 0) is lit.
  - With lz_en=0, digit0 is lit with bcd_out=0.
- Invalid BCD:
  - Stimulus: digit1=4'hC.
  - Required: digit1 seg_on=0, bcd_err rises and stays 1 after valid data is reloaded, until reset.
- Enable drop:
  - Stimulus: enable=0 during digit2 SHOW, then re-enable 7 cycles later.
  - Required: IDLE on the next cycle. Restart at sel=00 with frame_start. Shadow contents are unchanged.

Source files
------------

// File: rtl/digit_scan_controller.sv
// rtl/digit_scan_controller.sv - four-digit time-multiplexed display scan controller
//
// Steps a 1:4 digit-select demux through digits 0..3. Each digit slot is a
// blanking gap of BLANK_CYC cycles followed by a show window of SHOW_CYC
// cycles. Loaded time values are double-buffered: they only reach the
// displayed frame (shadow) at a frame boundary, so one frame never mixes
// old and new digits.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   enable_i       scan enable (level)
//   load_i         single-cycle strobe capturing digits_in_i
//   digits_in_i    {digit0, digit1, digit2, digit3}, BCD, digit0 in [15:12]
//   lz_en_i        suppress a leading zero on digit0
//   sel_o          demux select, d = {sel_o[0], sel_o[1]}
//   seg_on_o       segment enable (active high)
//   bcd_out_o      BCD code of the current digit
//   frame_start_o  one-cycle pulse on the first cycle of each frame
//   bcd_err_o      sticky: a non-BCD digit reached a show window
module digit_scan_controller #(
    parameter int SHOW_CYC  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        load_i,
    input  logic [15:0] digits_in_i,
    input  logic        lz_en_i,
    output logic [0:1]  sel_o,
    output logic        seg_on_o,
    output logic [3:0]  bcd_out_o,
    output logic        frame_start_o,
    output logic        bcd_err_o
);

    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_q, pend_d;
    logic [15:0]   shadow_q, shadow_d;

    logic [1:0]    sel_q, sel_d;
    logic          seg_on_q, seg_on_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          fs_q, fs_d;
    logic          err_q, err_d;

    logic          boundary;
    logic [3:0]    digit_d;

    // Next-state logic. A frame boundary is any transition into BLANK with
    // index 0: either leaving IDLE or wrapping past digit 3.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        if (!enable_i) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_BLANK;
                    idx_d    = 2'd0;
                    cnt_d    = '0;
                    boundary = 1'b1;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d  = S_BLANK;
                        cnt_d    = '0;
                        idx_d    = idx_q + 2'd1;
                        boundary = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double buffer. A load on the boundary itself bypasses pending so the
    // new value is shown in the frame that is just starting.
    always_comb begin
        pending_d = pending_q;
        pend_d    = pend_q;
        shadow_d  = shadow_q;
        if (load_i) begin
            if (boundary) begin
                shadow_d = digits_in_i;
                pend_d   = 1'b0;
            end else begin
                pending_d = digits_in_i;
                pend_d    = 1'b1;
            end
        end else if (boundary && pend_q) begin
            shadow_d = pending_q;
            pend_d   = 1'b0;
        end
    end

    always_comb begin
        case (idx_d)
            2'd0:    digit_d = shadow_d[15:12];
            2'd1:    digit_d = shadow_d[11:8];
            2'd2:    digit_d = shadow_d[7:4];
            default: digit_d = shadow_d[3:0];
        endcase
    end

    // Outputs are computed from the next state and registered alongside it,
    // so they line up with the state they describe. sel only moves when
    // entering BLANK, never while segments are lit.
    always_comb begin
        sel_d    = (state_d == S_IDLE) ? 2'd0 : idx_d;
        bcd_d    = (state_d == S_IDLE) ? 4'd0 : digit_d;
        seg_on_d = (state_d == S_SHOW) && (digit_d <= 4'd9) &&
                   !((idx_d == 2'd0) && lz_en_i && (digit_d == 4'd0));
        fs_d     = boundary;
        err_d    = err_q | ((state_d == S_SHOW) && (digit_d > 4'd9));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            pending_q <= 16'h0000;
            pend_q    <= 1'b0;
            shadow_q  <= 16'h0000;
            sel_q     <= 2'd0;
            seg_on_q  <= 1'b0;
            bcd_q     <= 4'd0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            shadow_q  <= shadow_d;
            sel_q     <= sel_d;
            seg_on_q  <= seg_on_d;
            bcd_q     <= bcd_d;
            fs_q      <= fs_d;
            err_q     <= err_d;
        end
    end

    // sel_o is declared [0:1]: sel_o[0] receives the index MSB.
    assign sel_o         = sel_q;
    assign seg_on_o      = seg_on_q;
    assign bcd_out_o     = bcd_q;
    assign frame_start_o = fs_q;
    assign bcd_err_o     = err_q;

endmodule
